mult_arbiter: RTL and testbench

Shares one pipelined 16x16 signed-by-unsigned multiplier between several requesters: filter state update, cutoff smoothing, output volume scaling. Grants one operation per cycle by round-robin, pushes the chosen operands into the multiplier pipeline and returns the Q0.16-scaled product to the requester that issued it. The block sits beside the filter datapath and replaces per-client multipliers, so all mono-SID clients fit on a single MAC.

---
 rtl/mult_arbiter_pkg.sv | 14 +
 rtl/mult_arbiter_if.sv | 22 ++
 rtl/mult_arbiter_mult_pipe.sv | 62 ++++++
 rtl/mult_arbiter.sv | 97 +++++++++
 tb/tb_mult_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
package mult_arbiter_pkg;

    // Operand and result width.
    localparam int unsigned DataW = 16;
    // Fractional bits dropped from the full product (Q0.16 coefficient).
    localparam int unsigned FracW = 16;

    // Width of a requester index; at least one bit.
    function automatic int unsigned tag_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bundle: requests and operands in, grants and results out.
interface mult_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*16-1:0] op_a;
    logic [NREQ*16-1:0] op_b;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [15:0]        rsp_data;
    logic               busy;

    modport master (
        output req, op_a, op_b,
        input  gnt, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req, op_a, op_b,
        output gnt, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mult_arbiter_mult_pipe.sv
// Registered signed-by-unsigned multiplier, LAT stages, no reset on data.
// Stage 0 holds the operands, later stages hold the scaled product; with
// LAT=2 this is the input-register/output-register shape of an SB_MAC16.
module mult_pipe
    import mult_arbiter_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic             clk_i,
    input  logic [LAT-1:0]   en_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    output logic [DataW-1:0] y_o
);

    logic [DataW-1:0]   a_q, a_d, b_q, b_d;
    logic signed [2*DataW:0] prod;
    logic [DataW-1:0]   prod_frac;
    logic               unused_prod_bits;

    // Operand capture only on an issue so the last result stays put.
    always_comb begin
        a_d = en_i[0] ? a_i : a_q;
        b_d = en_i[0] ? b_i : b_q;
    end

    // Operand registers.
    always_ff @(posedge clk_i) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Sign-extend a, zero-extend b; top bits of the slice cannot overflow.
    always_comb begin
        prod = $signed({{(DataW + 1){a_q[DataW-1]}}, a_q})
             * $signed({{(DataW + 1){1'b0}}, b_q});
        prod_frac = prod[FracW+DataW-1:FracW];
        unused_prod_bits = ^{prod[2*DataW], prod[FracW-1:0]};
    end

    if (LAT == 1) begin : g_comb_out
        assign y_o = prod_frac;
    end else begin : g_res
        logic [LAT-2:0][DataW-1:0] res_q, res_d;

        // Each result stage advances only when its incoming slot is valid.
        always_comb begin
            res_d[0] = en_i[1] ? prod_frac : res_q[0];
            for (int unsigned j = 1; j < LAT - 1; j++) begin
                res_d[j] = en_i[j+1] ? res_q[j-1] : res_q[j];
            end
        end

        // Product pipeline registers.
        always_ff @(posedge clk_i) begin
            res_q <= res_d;
        end

        assign y_o = res_q[LAT-2];
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ clients.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned LAT  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_arbiter_if.slave bus
);

    localparam int unsigned TagW = tag_width(NREQ);

    logic [TagW-1:0]           ptr_q, ptr_d;
    logic [NREQ-1:0]           gnt;
    logic                      issue;
    logic [TagW-1:0]           gnt_idx;
    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][TagW-1:0]  tag_q, tag_d;
    logic                      seen_q, seen_d;
    logic [LAT-1:0]            pipe_en;
    logic [DataW-1:0]          a_sel, b_sel, pipe_y;

    // Pick the first requester at or above ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        issue   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!issue && bus.req[idx[TagW-1:0]]) begin
                issue   = 1'b1;
                gnt_idx = idx[TagW-1:0];
            end
        end
        gnt   = issue ? (NREQ'(1) << gnt_idx) : '0;
        a_sel = bus.op_a[DataW*int'(gnt_idx) +: DataW];
        b_sel = bus.op_b[DataW*int'(gnt_idx) +: DataW];
    end

    // Next pointer, tag/valid shift and pipeline stage enables.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_idx == TagW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        vld_d      = '0;
        tag_d      = '0;
        pipe_en    = '0;
        vld_d[0]   = issue;
        tag_d[0]   = gnt_idx;
        pipe_en[0] = issue;
        for (int unsigned k = 1; k < LAT; k++) begin
            vld_d[k]   = vld_q[k-1];
            tag_d[k]   = tag_q[k-1];
            pipe_en[k] = vld_q[k-1];
        end
        seen_d = seen_q | vld_q[LAT-1];
    end

    // Control state; reset drops every in-flight tag and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            vld_q  <= '0;
            tag_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            seen_q <= seen_d;
        end
    end

    mult_pipe #(
        .LAT (LAT)
    ) u_mult_pipe (
        .clk_i (clk),
        .en_i  (pipe_en),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .y_o   (pipe_y)
    );

    // Response demux; data reads zero until the first result after reset.
    always_comb begin
        bus.gnt       = gnt;
        bus.rsp_valid = vld_q[LAT-1] ? (NREQ'(1) << tag_q[LAT-1]) : '0;
        bus.rsp_data  = (seen_q || vld_q[LAT-1]) ? pipe_y : '0;
        bus.busy      = |vld_q;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter (NREQ=3, LAT=2).
module tb_mult_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned LAT  = 2;

    typedef struct {
        int unsigned client;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [15:0]     data;
        int              cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] exp_val [NREQ];
    sb_t         sb [$];
    sb_t         mon_e;
    vec_t        vecs [10];

    mult_arbiter_if #(.NREQ(NREQ)) bus ();

    mult_arbiter #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int unsigned c, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e);
        bus.op_a[16*c +: 16] = a;
        bus.op_b[16*c +: 16] = b;
        exp_val[c] = e;
    endtask

    // Scoreboard: retire responses, then record the grant made this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(mon_e.mask));
                    chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                    chk("rsp_latency", 32'(cyc - mon_e.cyc), LAT);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc + int'(LAT)) begin
                mon_e = sb.pop_front();
                chk("missing_rsp", 32'(bus.rsp_valid), 32'(mon_e.mask));
            end
            if (bus.gnt != '0) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (bus.gnt[i]) sb.push_back('{mask: bus.gnt, data: exp_val[i], cyc: cyc});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 16'h4000, 16'h8000, 16'h2000};
        vecs[1] = '{0, 16'hFFFF, 16'h0001, 16'hFFFF};
        vecs[2] = '{2, 16'h8000, 16'hFFFF, 16'h8000};
        vecs[3] = '{0, 16'h7FFF, 16'hFFFF, 16'h7FFE};
        vecs[4] = '{1, 16'h0064, 16'h8000, 16'h0032};
        vecs[5] = '{2, 16'hFFF6, 16'h8000, 16'hFFFB};
        vecs[6] = '{0, 16'hFFF5, 16'h8000, 16'hFFFA};
        vecs[7] = '{1, 16'h1234, 16'h0000, 16'h0000};
        vecs[8] = '{2, 16'h0003, 16'h5555, 16'h0000};
        vecs[9] = '{0, 16'hFFFD, 16'h5555, 16'hFFFF};

        rst_n    = 1'b0;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        for (int i = 0; i < int'(NREQ); i++) exp_val[i] = '0;

        // Reset state, and gnt following req while in reset.
        step();
        step();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gnt_idle", 32'(bus.gnt), 32'd0);
        bus.req = 3'b100;
        #1;
        chk("rst_gnt_follow", 32'(bus.gnt), 32'b100);
        step();
        bus.req = '0;
        rst_n = 1'b1;
        step();

        // Single request: latency, busy window, data hold afterwards.
        set_op(1, 16'h4000, 16'h8000, 16'h2000);
        bus.req = 3'b010;
        #1;
        chk("single_gnt", 32'(bus.gnt), 32'b010);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("single_busy_t1", 32'(bus.busy), 32'd1);
        chk("single_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("single_busy_t2", 32'(bus.busy), 32'd1);
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b010);
        chk("single_rsp_data", 32'(bus.rsp_data), 32'h2000);
        @(negedge clk);
        chk("single_busy_t3", 32'(bus.busy), 32'd0);
        chk("single_rsp_idle", 32'(bus.rsp_valid), 32'd0);
        chk("single_data_hold", 32'(bus.rsp_data), 32'h2000);
        step();

        // Arithmetic vectors, issued back to back.
        for (int i = 0; i < 10; i++) begin
            set_op(vecs[i].client, vecs[i].a, vecs[i].b, vecs[i].exp);
            bus.req = NREQ'(1) << vecs[i].client;
            #1;
            chk("vec_gnt", 32'(bus.gnt), 32'(NREQ'(1) << vecs[i].client));
            step();
        end
        bus.req = '0;
        repeat (LAT + 1) step();
        chk("vec_drain", 32'(sb.size()), 32'd0);

        // All three held from reset: strict rotation 0,1,2,...
        rst_n = 1'b0;
        step();
        step();
        sb.delete();
        rst_n = 1'b1;
        set_op(0, 16'd1000, 16'h8000, 16'd500);
        set_op(1, 16'd2000, 16'h8000, 16'd1000);
        set_op(2, 16'd3000, 16'h8000, 16'd1500);
        bus.req = 3'b111;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_gnt", 32'(bus.gnt), 32'(3'b001 << (k % 3)));
            step();
        end
        bus.req = '0;

        // Pointer behaviour after a grant to 2, and wrap-around search.
        set_op(0, 16'h0200, 16'h4000, 16'h0080);
        set_op(1, 16'hFE00, 16'h4000, 16'hFF80);
        set_op(2, 16'h0100, 16'hFFFF, 16'h00FF);
        bus.req = 3'b100;
        #1;
        chk("ptr_only2", 32'(bus.gnt), 32'b100);
        step();
        bus.req = 3'b101;
        #1;
        chk("ptr_0_first", 32'(bus.gnt), 32'b001);
        step();
        bus.req = 3'b100;
        #1;
        chk("ptr_then_2", 32'(bus.gnt), 32'b100);
        step();
        bus.req = 3'b110;
        #1;
        chk("ptr_pick1", 32'(bus.gnt), 32'b010);
        step();
        bus.req = 3'b011;
        #1;
        chk("ptr_wrap", 32'(bus.gnt), 32'b001);
        step();
        bus.req = '0;
        repeat (LAT + 1) step();
        chk("ptr_drain", 32'(sb.size()), 32'd0);

        // Burst on one client with changing operands.
        for (int k = 0; k < 4; k++) begin
            set_op(0, 16'(100 * (k + 1)), 16'h8000, 16'(50 * (k + 1)));
            bus.req = 3'b001;
            #1;
            chk("burst_gnt", 32'(bus.gnt), 32'b001);
            step();
        end
        bus.req = '0;
        repeat (LAT + 1) step();
        chk("burst_drain", 32'(sb.size()), 32'd0);

        // Reset with two operations in flight: nothing may come back.
        set_op(1, 16'h0400, 16'h8000, 16'h0200);
        bus.req = 3'b010;
        step();
        step();
        bus.req = '0;
        rst_n = 1'b0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < int'(LAT) + 1; k++) begin
            @(negedge clk);
            chk("flush_busy", 32'(bus.busy), 32'd0);
            chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("flush_rsp_data", 32'(bus.rsp_data), 32'd0);
        end
        step();
        set_op(1, 16'h0600, 16'h8000, 16'h0300);
        set_op(2, 16'h0800, 16'h8000, 16'h0400);
        bus.req = 3'b110;
        #1;
        chk("post_rst_ptr", 32'(bus.gnt), 32'b010);
        step();
        bus.req = '0;
        repeat (LAT + 1) step();
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
